fdiv_param: RTL and testbench
=============================

FDIV_PARAM -- requirements
Module: fdiv_param

Interface
REQ-001 EXP_W, 8, exponent field width; legal range 5..11.
REQ-002 MAN_W, 23, stored fraction width; legal range 4..52.
REQ-003 Derived constants: W=1+EXP_W+MAN_W; BIAS=2^(EXP_W-1)-1; Q=MAN_W+4 quotient bits.
REQ-004 clk  input  1  clock, all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 in_a  input  W  dividend operand.
REQ-007 in_b  input  W  divisor operand.
REQ-008 in_rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-009 in_valid  input  1  operands and mode present.
REQ-010 in_ready  output  1  block accepts operands; high only in IDLE.
REQ-011 out_z  output  W  quotient a/b.
REQ-012 out_flags  output  5  {NV, DZ, OF, UF, NX} exception flags for out_z.
REQ-013 out_valid  output  1  out_z/out_flags valid.
REQ-014 out_ready  input  1  consumer accepts result.

Function
REQ-015 Input transfer SHALL occur on a cycle with in_valid and in_ready both high; in_a, in_b, in_rm captured that cycle; inputs ignored at all other times.
REQ-016 States: IDLE, SPECIAL, NORM_IN, DIV, NORM_OUT, ROUND, OUT; IDLE->SPECIAL on input transfer.
REQ-017 SPECIAL (1 cycle): NaN operand, 0/0 or inf/inf -> canonical qNaN (sign 0, exponent all ones, fraction MSB 1, rest 0), NV; x/0 (x finite nonzero) -> inf with sign a_s^b_s, DZ; inf/finite -> signed inf; finite/inf or 0/nonzero -> signed zero; these go directly to OUT with no other flags.
REQ-018 NORM_IN: one cycle minimum; each subnormal operand shifted left one bit per extra cycle until hidden bit set, exponent decremented per shift.
REQ-019 DIV: restoring radix-2, exactly Q cycles, one quotient bit per cycle; sticky = OR of nonzero final remainder.
REQ-020 NORM_OUT: if quotient MSB is 0, shift left once and decrement exponent (1 cycle); if exponent below minimum normal, right-shift one bit per extra cycle into guard/round/sticky.
REQ-021 ROUND (1 cycle): increment per in_rm and sign using guard, round, sticky, LSB; mantissa carry-out increments exponent; NX when any discarded bit nonzero.
REQ-022 Overflow (exponent > BIAS after rounding): OF|NX; RNE -> signed inf; RTZ -> signed max finite; RDN -> +max finite / -inf; RUP -> +inf / -max finite.
REQ-023 UF set when result tiny after rounding and NX set.
REQ-024 Latency, normal operands and normal result: out_valid rises exactly Q+5 cycles after input-transfer cycle (32 for defaults); special cases: exactly 2 cycles.
REQ-025 OUT: out_valid high, out_z/out_flags stable until out_ready high; transfer cycle -> IDLE next cycle; in_ready therefore low during transfer cycle.
REQ-026 Back-to-back: new input accepted earliest the cycle after output transfer.

Reset
REQ-027 rst low SHALL immediately force IDLE, out_valid 0, out_z 0, out_flags 0, in_ready 1, regardless of operation in progress.
REQ-028 Operation aborted by reset SHALL produce no output; first transfer after release behaves as from power-up.

Configuration
REQ-029 Macro FDIV_SUBNORMAL_EN defined: full subnormal input normalisation and subnormal output per REQ-018/020.
REQ-030 Macro undefined: subnormal inputs treated as signed zero (no flag); tiny results flushed to signed zero with UF|NX; NORM_IN and NORM_OUT right-shift loops removed, so latency is fixed per REQ-024 for all non-special inputs.

Verification (defaults EXP_W=8, MAN_W=23)
REQ-031 0x3F800000/0x40000000, RNE -> 0x3F000000, flags 0, out_valid exactly 32 cycles after transfer.
REQ-032 0x3F800000/0x40400000: RNE -> 0x3EAAAAAB NX; RTZ -> 0x3EAAAAAA NX.
REQ-033 0x3F800000/0x00000000 -> 0x7F800000 DZ; 0x00000000/0x00000000 -> 0x7FC00000 NV; both after 2 cycles.
REQ-034 0x7F7FFFFF/0x3F000000: RNE -> 0x7F800000 OF|NX; RTZ -> 0x7F7FFFFF OF|NX.
REQ-035 0x00800000/0x40000000: with FDIV_SUBNORMAL_EN -> 0x00400000 flags 0; without -> 0x00000000 UF|NX.
REQ-036 out_ready held low 10 cycles -> out_z/out_valid stable, in_ready low; rst pulsed mid-DIV -> no output, next division correct.

Source files
------------

// File: rtl/fdiv_param.sv
// Multi-cycle IEEE-style floating-point divider (restoring radix-2, one quotient bit per cycle).
// Define FDIV_SUBNORMAL_EN for full subnormal support; otherwise subnormals are flushed to zero.
module fdiv_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MAN_W:0]     in_a,
    input  logic [EXP_W+MAN_W:0]     in_b,
    input  logic [1:0]               in_rm,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [EXP_W+MAN_W:0]     out_z,
    output logic [4:0]               out_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               dbg_state
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int Q    = MAN_W + 4;
    localparam int M    = MAN_W + 1;
    localparam int EW   = EXP_W + 3;
    localparam int CW   = $clog2(Q + 1);

    localparam logic signed [EW-1:0] E_ZERO = '0;
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
    localparam logic signed [EW-1:0] E_OVF  = EW'((1 << EXP_W) - 1);

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high;
    // the producer holds its payload steady while valid is high and ready is low.
    typedef enum logic [2:0] {
        S_IDLE, S_SPECIAL, S_NORM_IN, S_DIV, S_NORM_OUT, S_ROUND, S_OUT
    } state_t;

    state_t r_state, w_next;

    logic [W-1:0]          r_a, r_b;
    logic [1:0]            r_rm;
    logic                  r_sign;
    logic [M-1:0]          r_ma, r_mb;
    logic signed [EW-1:0]  r_ea, r_eb, r_exp;
    logic [M:0]            r_rem;
    logic [Q-1:0]          r_quo;
    logic [CW-1:0]         r_cnt;
    logic                  r_sticky;
    logic                  r_lsh_done;
    logic [W-1:0]          r_z;
    logic [4:0]            r_flags;

    // Operand field decode
    logic              w_a_s, w_b_s;
    logic [EXP_W-1:0]  w_a_e, w_b_e;
    logic [MAN_W-1:0]  w_a_f, w_b_f;
    logic              w_a_ez, w_b_ez, w_a_emax, w_b_emax;
    logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_a_s    = r_a[W-1];
    assign w_b_s    = r_b[W-1];
    assign w_a_e    = r_a[W-2:MAN_W];
    assign w_b_e    = r_b[W-2:MAN_W];
    assign w_a_f    = r_a[MAN_W-1:0];
    assign w_b_f    = r_b[MAN_W-1:0];
    assign w_a_ez   = ~|w_a_e;
    assign w_b_ez   = ~|w_b_e;
    assign w_a_emax = &w_a_e;
    assign w_b_emax = &w_b_e;
    assign w_a_nan  = w_a_emax & |w_a_f;
    assign w_b_nan  = w_b_emax & |w_b_f;
    assign w_a_inf  = w_a_emax & ~|w_a_f;
    assign w_b_inf  = w_b_emax & ~|w_b_f;

`ifdef FDIV_SUBNORMAL_EN
    assign w_a_zero = w_a_ez & ~|w_a_f;
    assign w_b_zero = w_b_ez & ~|w_b_f;
`else
    assign w_a_zero = w_a_ez;
    assign w_b_zero = w_b_ez;
`endif

    logic w_sp_nan, w_sp_dz, w_sp_inf, w_sp_zero, w_special;
    assign w_sp_nan  = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_sp_dz   = ~w_sp_nan & w_b_zero & ~w_a_inf;
    assign w_sp_inf  = ~w_sp_nan & w_a_inf;
    assign w_sp_zero = ~w_sp_nan & (w_b_inf | w_a_zero);
    assign w_special = w_sp_nan | w_sp_dz | w_sp_inf | w_sp_zero;

    // Operand normalisation
    logic w_in_done;
`ifdef FDIV_SUBNORMAL_EN
    assign w_in_done = r_ma[M-1] & r_mb[M-1];
`else
    assign w_in_done = 1'b1;
`endif

    // Restoring division step
    logic [M:0] w_divisor, w_diff;
    logic       w_ge;
    assign w_divisor = {1'b0, r_mb};
    assign w_ge      = r_rem >= w_divisor;
    assign w_diff    = r_rem - w_divisor;

    // Output normalisation
    logic                 w_msb0;
    logic signed [EW-1:0] w_exp_n;
    assign w_msb0  = ~r_quo[Q-1];
    assign w_exp_n = w_msb0 ? (r_exp - E_ONE) : r_exp;

`ifdef FDIV_SUBNORMAL_EN
    // Right shifting stops at the minimum normal exponent or once every bit has gone to sticky.
    logic [Q-1:0] w_quo_rsh;
    logic         w_rsh_end;
    assign w_quo_rsh = r_quo >> 1;
    assign w_rsh_end = (r_exp == E_ZERO) | (w_quo_rsh == '0);
`endif

    // Rounding
    logic [M-1:0]         w_mant;
    logic                 w_g, w_r, w_st, w_nx, w_inc, w_carry, w_hidden, w_ovf, w_ovf_inf;
    logic [M:0]           w_sum;
    logic [MAN_W-1:0]     w_frac;
    logic signed [EW-1:0] w_exp_r;

    always_comb begin
        w_mant = r_quo[Q-1:3];
        w_g    = r_quo[2];
        w_r    = r_quo[1];
        w_st   = r_quo[0] | r_sticky;
        w_nx   = w_g | w_r | w_st;
        w_inc  = 1'b0;
        case (r_rm)
            RM_RNE:  w_inc = w_g & (w_r | w_st | w_mant[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_sign & w_nx;
            default: w_inc = ~r_sign & w_nx;
        endcase
        w_sum     = {1'b0, w_mant} + {{M{1'b0}}, w_inc};
        w_carry   = w_sum[M];
        w_hidden  = w_sum[M] | w_sum[M-1];
        w_frac    = w_carry ? {MAN_W{1'b0}} : w_sum[MAN_W-1:0];
        w_exp_r   = r_exp + (w_carry ? E_ONE : E_ZERO);
        w_ovf     = w_exp_r >= E_OVF;
        w_ovf_inf = (r_rm == RM_RNE) | ((r_rm == RM_RDN) & r_sign) | ((r_rm == RM_RUP) & ~r_sign);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (in_valid) w_next = S_SPECIAL;
            S_SPECIAL:  w_next = w_special ? S_OUT : S_NORM_IN;
            S_NORM_IN:  if (w_in_done) w_next = S_DIV;
            S_DIV:      if (r_cnt == CW'(Q - 1)) w_next = S_NORM_OUT;
`ifdef FDIV_SUBNORMAL_EN
            S_NORM_OUT: begin
                if (!r_lsh_done) w_next = (w_exp_n < E_ONE) ? S_NORM_OUT : S_ROUND;
                else             w_next = w_rsh_end ? S_ROUND : S_NORM_OUT;
            end
`else
            S_NORM_OUT: w_next = S_ROUND;
`endif
            S_ROUND:    w_next = S_OUT;
            S_OUT:      if (out_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_rm       <= '0;
            r_sign     <= 1'b0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_ea       <= '0;
            r_eb       <= '0;
            r_exp      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_lsh_done <= 1'b0;
            r_z        <= '0;
            r_flags    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a  <= in_a;
                        r_b  <= in_b;
                        r_rm <= in_rm;
                    end
                end
                S_SPECIAL: begin
                    r_sign <= w_a_s ^ w_b_s;
                    r_ma   <= {~w_a_ez, w_a_f};
                    r_mb   <= {~w_b_ez, w_b_f};
                    r_ea   <= w_a_ez ? E_ONE : EW'(w_a_e);
                    r_eb   <= w_b_ez ? E_ONE : EW'(w_b_e);
                    if (w_sp_nan) begin
                        r_z     <= {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                        r_flags <= 5'b10000;
                    end else if (w_sp_dz) begin
                        r_z     <= {w_a_s ^ w_b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_flags <= 5'b01000;
                    end else if (w_sp_inf) begin
                        r_z     <= {w_a_s ^ w_b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_flags <= 5'b00000;
                    end else if (w_sp_zero) begin
                        r_z     <= {w_a_s ^ w_b_s, {(W-1){1'b0}}};
                        r_flags <= 5'b00000;
                    end
                end
                S_NORM_IN: begin
                    if (w_in_done) begin
                        r_rem      <= {1'b0, r_ma};
                        r_exp      <= r_ea - r_eb + E_BIAS;
                        r_quo      <= '0;
                        r_cnt      <= '0;
                        r_sticky   <= 1'b0;
                        r_lsh_done <= 1'b0;
                    end else begin
                        if (!r_ma[M-1]) begin
                            r_ma <= r_ma << 1;
                            r_ea <= r_ea - E_ONE;
                        end
                        if (!r_mb[M-1]) begin
                            r_mb <= r_mb << 1;
                            r_eb <= r_eb - E_ONE;
                        end
                    end
                end
                S_DIV: begin
                    // Partial remainder stays below twice the divisor, so M+1 bits never overflow.
                    r_rem <= (w_ge ? w_diff : r_rem) << 1;
                    r_quo <= {r_quo[Q-2:0], w_ge};
                    r_cnt <= r_cnt + CW'(1);
                end
                S_NORM_OUT: begin
                    if (!r_lsh_done) begin
                        r_sticky   <= r_sticky | (r_rem != '0);
                        r_lsh_done <= 1'b1;
                        r_exp      <= w_exp_n;
                        if (w_msb0) r_quo <= r_quo << 1;
                    end
`ifdef FDIV_SUBNORMAL_EN
                    else begin
                        r_quo    <= w_quo_rsh;
                        r_sticky <= r_sticky | r_quo[0];
                        r_exp    <= w_rsh_end ? E_ONE : (r_exp + E_ONE);
                    end
`endif
                end
                S_ROUND: begin
`ifndef FDIV_SUBNORMAL_EN
                    if (r_exp < E_ONE) begin
                        r_z     <= {r_sign, {(W-1){1'b0}}};
                        r_flags <= 5'b00011;
                    end else
`endif
                    if (w_ovf) begin
                        r_z     <= w_ovf_inf ? {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                             : {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                        r_flags <= 5'b00101;
                    end else begin
                        r_z     <= {r_sign, (w_hidden ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
                        r_flags <= {3'b000, ~w_hidden & w_nx, w_nx};
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_z     = r_z;
    assign out_flags = r_flags;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fdiv_param.sv
// Directed bench for fdiv_param at default widths (binary32): vector table plus handshake/reset sequences.
module tb_fdiv_param;

    localparam logic [1:0] RNE = 2'b00;
    localparam logic [1:0] RTZ = 2'b01;
    localparam logic [1:0] RDN = 2'b10;
    localparam logic [1:0] RUP = 2'b11;
    localparam int LAT_N = 32;
    localparam int LAT_S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_a, in_b;
    logic [1:0]  in_rm;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_z;
    logic [4:0]  out_flags;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    fdiv_param dut (
        .clk       (clk),
        .rst       (rst),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_rm     (in_rm),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_z     (out_z),
        .out_flags (out_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] z;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                           input logic [31:0] z, input logic [4:0] f, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.rm = rm; v.z = z; v.f = f; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Wait (bounded) for out_valid, counting cycles since the transfer edge.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                          output logic [31:0] z, output logic [4:0] f, output int lat);
        int guard;
        @(negedge clk);
        in_a = a; in_b = b; in_rm = rm; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        z = out_z;
        f = out_flags;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] z;
        logic [4:0]  f;
        int          lat;
        int          seen;

        in_a = '0; in_b = '0; in_rm = RNE; in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_z", 64'(out_z), 64'd0);
        check("reset_out_flags", 64'(out_flags), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk) rst = 1'b1;

        add_vec(32'h3F800000, 32'h40000000, RNE, 32'h3F000000, 5'b00000, LAT_N);
        add_vec(32'h3F800000, 32'h40400000, RNE, 32'h3EAAAAAB, 5'b00001, LAT_N);
        add_vec(32'h3F800000, 32'h40400000, RTZ, 32'h3EAAAAAA, 5'b00001, LAT_N);
        add_vec(32'h3F800000, 32'h40400000, RDN, 32'h3EAAAAAA, 5'b00001, LAT_N);
        add_vec(32'h3F800000, 32'h40400000, RUP, 32'h3EAAAAAB, 5'b00001, LAT_N);
        add_vec(32'hBF800000, 32'h40400000, RDN, 32'hBEAAAAAB, 5'b00001, LAT_N);
        add_vec(32'hBF800000, 32'h40400000, RUP, 32'hBEAAAAAA, 5'b00001, LAT_N);
        add_vec(32'h40C00000, 32'h40000000, RNE, 32'h40400000, 5'b00000, LAT_N);
        add_vec(32'h40A00000, 32'h40400000, RNE, 32'h3FD55555, 5'b00001, LAT_N);
        add_vec(32'h3F800000, 32'h00000000, RNE, 32'h7F800000, 5'b01000, LAT_S);
        add_vec(32'hBF800000, 32'h00000000, RNE, 32'hFF800000, 5'b01000, LAT_S);
        add_vec(32'h00000000, 32'h00000000, RNE, 32'h7FC00000, 5'b10000, LAT_S);
        add_vec(32'h7F800000, 32'h7F800000, RNE, 32'h7FC00000, 5'b10000, LAT_S);
        add_vec(32'h7FC00000, 32'h3F800000, RNE, 32'h7FC00000, 5'b10000, LAT_S);
        add_vec(32'hFF800000, 32'h3F800000, RNE, 32'hFF800000, 5'b00000, LAT_S);
        add_vec(32'h3F800000, 32'hFF800000, RNE, 32'h80000000, 5'b00000, LAT_S);
        add_vec(32'h80000000, 32'h3F800000, RNE, 32'h80000000, 5'b00000, LAT_S);
        add_vec(32'h7F7FFFFF, 32'h3F000000, RNE, 32'h7F800000, 5'b00101, LAT_N);
        add_vec(32'h7F7FFFFF, 32'h3F000000, RTZ, 32'h7F7FFFFF, 5'b00101, LAT_N);
        add_vec(32'h7F7FFFFF, 32'h3F000000, RDN, 32'h7F7FFFFF, 5'b00101, LAT_N);
        add_vec(32'h7F7FFFFF, 32'h3F000000, RUP, 32'h7F800000, 5'b00101, LAT_N);
        add_vec(32'hFF7FFFFF, 32'h3F000000, RDN, 32'hFF800000, 5'b00101, LAT_N);
        add_vec(32'hFF7FFFFF, 32'h3F000000, RUP, 32'hFF7FFFFF, 5'b00101, LAT_N);
`ifdef FDIV_SUBNORMAL_EN
        add_vec(32'h00800000, 32'h40000000, RNE, 32'h00400000, 5'b00000, LAT_N + 1);
        add_vec(32'h00000001, 32'h3F800000, RNE, 32'h00000001, 5'b00000, 78);
`else
        add_vec(32'h00800000, 32'h40000000, RNE, 32'h00000000, 5'b00011, LAT_N);
        add_vec(32'h00000001, 32'h3F800000, RNE, 32'h00000000, 5'b00000, LAT_S);
`endif

        foreach (vecs[i]) begin
            exp_q.push_back(vecs[i].z);
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, z, f, lat);
            check($sformatf("vec%0d_z", i), 64'(z), 64'(exp_q.pop_front()));
            check($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].f));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
        end

        // Back-pressure: result must hold while a competing request waits.
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h40400000; in_rm = RNE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_a = 32'h40C00000; in_b = 32'h40000000; in_rm = RNE;
        wait_out(lat);
        check("stall_latency", 64'(lat), 64'(LAT_N));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold%0d", i), {31'd0, out_valid, in_ready, out_z},
                  {31'd0, 1'b1, 1'b0, 32'h3EAAAAAB});
        end
        out_ready = 1'b1;
        check("stall_xfer_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        check("b2b_latency", 64'(lat), 64'(LAT_N));
        check("b2b_z", 64'(out_z), 64'h40400000);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Reset in the middle of the division loop.
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h40400000; in_rm = RNE; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_z", 64'(out_z), 64'd0);
        check("midrst_out_flags", 64'(out_flags), 64'd0);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_output", 64'(seen), 64'd0);
        run_op(32'h40A00000, 32'h40400000, RNE, z, f, lat);
        check("post_rst_z", 64'(z), 64'h3FD55555);
        check("post_rst_flags", 64'(f), 64'h01);
        check("post_rst_latency", 64'(lat), 64'(LAT_N));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
